// File: rtl/cpu_defs.sv
// Shared CPU datapath definitions: MIPS field slice positions and queue defaults.
package cpu_defs;
  localparam int OP_HI  = 31, OP_LO  = 26;
  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int SH_HI  = 10, SH_LO  = 6;
  localparam int FN_HI  = 5,  FN_LO  = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int TGT_HI = 25, TGT_LO = 0;

  localparam logic [31:0] NOP_INST = 32'h0;
  localparam int          IQ_DEPTH = 4;
endpackage

// File: rtl/inst_field_split.sv
// Combinational MIPS field slicer; shared by the instruction queue and decode.
module inst_field_split
  import cpu_defs::*;
(
  input  logic [31:0] inst,
  output logic [5:0]  OpCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [15:0] Imm16,
  output logic [25:0] Target26
);
  assign OpCode   = inst[OP_HI:OP_LO];
  assign rs       = inst[RS_HI:RS_LO];
  assign rt       = inst[RT_HI:RT_LO];
  assign rd       = inst[RD_HI:RD_LO];
  assign Shamt    = inst[SH_HI:SH_LO];
  assign Funct    = inst[FN_HI:FN_LO];
  assign Imm16    = inst[IMM_HI:IMM_LO];
  assign Target26 = inst[TGT_HI:TGT_LO];
endmodule

// File: rtl/inst_queue.sv
// DEPTH-entry {instruction, PC} FIFO between fetch and the control FSM.
// Head is zero-gated when empty so decode sees a nop, and pre-split into fields.
module inst_queue
  import cpu_defs::*;
#(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_W-1:0]        in_inst,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [INST_W-1:0]        out_inst,
  output logic [PC_W-1:0]          out_pc,
  output logic [5:0]               OpCode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               Shamt,
  output logic [5:0]               Funct,
  output logic [15:0]              Imm16,
  output logic [25:0]              Target26,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic              push, pop;

  // Ready/valid come only from registered count: no ready-through-pop path.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_ready && out_valid && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage is never reset; out_valid gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

  assign out_inst = out_valid ? mem_inst[rd_ptr] : INST_W'(NOP_INST);
  assign out_pc   = out_valid ? mem_pc[rd_ptr]   : '0;

  inst_field_split u_split (
    .inst     (out_inst),
    .OpCode   (OpCode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .Shamt    (Shamt),
    .Funct    (Funct),
    .Imm16    (Imm16),
    .Target26 (Target26)
  );
endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: expected {inst,pc} queued on accepted push, compared on pop.
module tb_inst_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [5:0]  OpCode;
  logic [4:0]  rs, rt, rd, Shamt;
  logic [5:0]  Funct;
  logic [15:0] Imm16;
  logic [25:0] Target26;
  logic [2:0]  count;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb [$];
  int unsigned seq = 0;

  always #5 clk = ~clk;

  inst_queue #(.INST_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_ready(out_ready), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .OpCode(OpCode), .rs(rs), .rt(rt), .rd(rd), .Shamt(Shamt), .Funct(Funct),
    .Imm16(Imm16), .Target26(Target26), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check pre-edge handshake/head against the model, advance model, check count.
  task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                     input logic r, input logic f);
    bit do_pop, do_push;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = r; flush = f;
    #1;
    check("in_ready", in_ready, sb.size() < DEPTH);
    check("out_valid", out_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      check("head_inst", out_inst, sb[0][63:32]);
      check("head_pc", out_pc, sb[0][31:0]);
    end else begin
      check("empty_inst", out_inst, 0);
    end
    if (f) begin
      sb.delete();
    end else begin
      do_pop  = r && (sb.size() > 0);
      do_push = v && (sb.size() < DEPTH);
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back({inst, pc});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    check("count", count, sb.size());
  endtask

  task automatic push_new(input logic r);
    seq++;
    cyc(1'b1, 32'h2000_0000 + seq, 32'h0040_0000 + 4 * seq, r, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_opcode", OpCode, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // add $t0,$t1,$t2 then field decode of the head
    cyc(1'b1, 32'h012A4020, 32'h0040_0000, 1'b0, 1'b0);
    check("add_valid", out_valid, 1);
    check("add_opcode", OpCode, 0);
    check("add_rs", rs, 9);
    check("add_rt", rt, 10);
    check("add_rd", rd, 8);
    check("add_shamt", Shamt, 0);
    check("add_funct", Funct, 6'h20);
    check("add_imm16", Imm16, 16'h4020);
    check("add_tgt26", Target26, 26'h12A4020);
    check("add_count", count, 1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // fill, refused 5th push, full push+pop, refill, drain in order
    repeat (4) push_new(1'b0);
    check("full_ready", in_ready, 0);
    push_new(1'b0);
    push_new(1'b1);
    check("full_pp_count", count, 3);
    push_new(1'b0);
    check("refill_count", count, 4);
    repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // steady push+pop: ten pushes walk the pointers around twice
    push_new(1'b0);
    repeat (10) push_new(1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // random mix
    for (int i = 0; i < 40; i++) begin
      seq++;
      cyc(1'($urandom_range(0, 1)), $urandom, 32'h0040_0000 + 4 * seq,
          1'($urandom_range(0, 1)), 1'b0);
      check("count_le_depth", count <= DEPTH, 1);
    end
    while (sb.size() > 0) cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // flush beats concurrent push and pop
    repeat (3) push_new(1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 32'h0BAD_0000, 1'b1, 1'b1);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_opcode", OpCode, 0);
    check("flush_ready", in_ready, 1);
    push_new(1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // async reset between edges
    repeat (2) push_new(1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", out_valid, 0);
    check("arst_inst", out_inst, 0);
    check("arst_pc", out_pc, 0);
    check("arst_funct", Funct, 0);
    check("arst_ready", in_ready, 1);
    sb.delete();
    #1 reset = 1'b0;
    @(posedge clk); #1;
    push_new(1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised instruction holding buffer for the multi-cycle CPU datapath.
- Replaces the single-entry instruction register with a DEPTH-entry FIFO of {instruction, PC} pairs.
- Fetch logic pushes words at its own rate; the control FSM pops one instruction per decode.
- The head entry is exposed as pre-split MIPS fields, so decode needs no extra register stage.

Parameters:
- INST_W, 32, instruction word width; must be 32 for the field split.
- PC_W, 32, width of the stored fetch PC.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all entries; branch, jump or exception redirect
- in_valid  input  1  fetch presents a word
- in_ready  output  1  queue can accept (registered, equals !full)
- in_inst  input  INST_W  fetched instruction
- in_pc  input  PC_W  PC of fetched instruction
- out_ready  input  1  control FSM consumes head (IRWrite-equivalent)
- out_valid  output  1  head entry valid (equals !empty)
- out_inst  output  INST_W  head instruction
- out_pc  output  PC_W  head PC
- OpCode  output  6  head[31:26]
- rs  output  5  head[25:21]
- rt  output  5  head[20:16]
- rd  output  5  head[15:11]
- Shamt  output  5  head[10:6]
- Funct  output  6  head[5:0]
- Imm16  output  16  head[15:0]
- Target26  output  26  head[25:0]
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (asynchronous, immediate):
  - count=0; rd_ptr=wr_ptr=0.
  - in_ready=1, out_valid=0.
  - All data and field outputs read 0.
  - Storage contents need not be cleared.
- Push: in_valid && in_ready at a rising edge writes {in_inst,in_pc} to mem[wr_ptr] and increments wr_ptr, wrapping at DEPTH.
- Pop: out_ready && out_valid at a rising edge increments rd_ptr, wrapping at DEPTH.
- Latency: a word pushed into an empty queue appears on the outputs with out_valid=1 in the cycle after the push edge. There is no same-cycle bypass.
- Output gating: out_inst, out_pc and all field outputs are driven from mem[rd_ptr] when out_valid=1, and forced to 0 when out_valid=0. An empty queue therefore decodes as opcode 0 / funct 0 (nop).
- Simultaneous push and pop:
  - count is unchanged.
  - When full, push is refused because in_ready=0. No combinational ready-through-pop path.
- Pop while empty: ignored; pointers and count are unchanged.
- Push while full: ignored; no overwrite.
- Count update per edge:
  - +1 on push-only.
  - -1 on pop-only.
  - Unchanged when both or neither occur.
- in_ready and out_valid are derived combinationally from the registered count, so they are glitch-free with respect to the inputs.
- Flush has priority over push and pop in the same cycle:
  - rd_ptr=wr_ptr=0 and count=0 at the edge.
  - The concurrent push is dropped.
  - The next cycle shows out_valid=0 and in_ready=1.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is decided by count, never by pointer compare.
- Reset asserted mid-operation clears state immediately, independent of clk. Deassertion is synchronous to the design's reset synchroniser.

Decomposition:
- Shared package cpu_defs holds:
  - field-slice constants (OP_HI=31, OP_LO=26, RS_HI=25, etc.);
  - NOP_INST=32'h0;
  - the default DEPTH.
- One natural sub-module: inst_field_split, a purely combinational slicer from a 32-bit word to OpCode/rs/rt/rd/Shamt/Funct/Imm16/Target26. It is reused by the decode stage.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset, then push 32'h012A4020 (add $t0,$t1,$t2) at PC 0x00400000:
  - next cycle out_valid=1;
  - OpCode=0, rs=9, rt=10, rd=8, Shamt=0, Funct=0x20, count=1.
- Push 4 words with no pops (DEPTH=4):
  - count=4, in_ready=0;
  - a 5th push with in_valid=1 is ignored;
  - pops return the 4 words in order with matching PCs.
- Full queue, in_valid=1 and out_ready=1 on the same edge:
  - one pop, no push, count=3;
  - next edge pushes, count=4.
- Run 10 push/pop cycles to force pointer wrap twice:
  - data order is preserved;
  - count stays within 0..4.
- With 3 entries, assert flush together with in_valid=1 and out_ready=1:
  - next cycle count=0, out_valid=0, OpCode=0, in_ready=1;
  - the flushed push never appears.
- Assert reset asynchronously between clock edges with 2 entries:
  - outputs go to 0 and count=0 before the next edge;
  - after release, normal push works.
